// File: rtl/sseg_pkg.sv
// Shared segment codes, bit order and parameter limits for the seven-segment scan controller.
package sseg_pkg;

  localparam int unsigned SEG_W = 8;

  // Cathode bit positions, active-low: {dp,g,f,e,d,c,b,a}
  typedef enum int unsigned {
    SEG_A  = 0,
    SEG_B  = 1,
    SEG_C  = 2,
    SEG_D  = 3,
    SEG_E  = 4,
    SEG_F  = 5,
    SEG_G  = 6,
    SEG_DP = 7
  } seg_bit_e;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  localparam seg_t SEG_HEX_0 = 8'hC0;
  localparam seg_t SEG_HEX_1 = 8'hF9;
  localparam seg_t SEG_HEX_2 = 8'hA4;
  localparam seg_t SEG_HEX_3 = 8'hB0;
  localparam seg_t SEG_HEX_4 = 8'h99;
  localparam seg_t SEG_HEX_5 = 8'h92;
  localparam seg_t SEG_HEX_6 = 8'h82;
  localparam seg_t SEG_HEX_7 = 8'hF8;
  localparam seg_t SEG_HEX_8 = 8'h80;
  localparam seg_t SEG_HEX_9 = 8'h90;
  localparam seg_t SEG_HEX_A = 8'h88;
  localparam seg_t SEG_HEX_B = 8'h83;
  localparam seg_t SEG_HEX_C = 8'hC6;
  localparam seg_t SEG_HEX_D = 8'hA1;
  localparam seg_t SEG_HEX_E = 8'h86;
  localparam seg_t SEG_HEX_F = 8'h8E;

  localparam int unsigned MIN_DIGITS       = 1;
  localparam int unsigned MAX_DIGITS       = 16;
  localparam int unsigned MIN_BLINK_FRAMES = 1;
  // Slot must hold the guard time plus at least two lit cycles
  localparam int unsigned MIN_SLOT_MARGIN  = 2;

endpackage

// File: rtl/sseg_decode.sv
// Combinational hex nibble + decimal point to active-low segment code.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (nibble)
      4'h0: seg_c = SEG_HEX_0;
      4'h1: seg_c = SEG_HEX_1;
      4'h2: seg_c = SEG_HEX_2;
      4'h3: seg_c = SEG_HEX_3;
      4'h4: seg_c = SEG_HEX_4;
      4'h5: seg_c = SEG_HEX_5;
      4'h6: seg_c = SEG_HEX_6;
      4'h7: seg_c = SEG_HEX_7;
      4'h8: seg_c = SEG_HEX_8;
      4'h9: seg_c = SEG_HEX_9;
      4'hA: seg_c = SEG_HEX_A;
      4'hB: seg_c = SEG_HEX_B;
      4'hC: seg_c = SEG_HEX_C;
      4'hD: seg_c = SEG_HEX_D;
      4'hE: seg_c = SEG_HEX_E;
      4'hF: seg_c = SEG_HEX_F;
      default: seg_c = SEG_BLANK;
    endcase
    seg_c[SEG_DP] = ~dp;
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scanner: prescaled digit scan, frame-synchronous shadow
// loading, blink and leading-zero blanking, registered active-low anode/cathode.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned BLINK_FRAMES = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   anode,
  output seg_t                    cathode,
  output logic                    frame_tick
);

  localparam int unsigned HEX_W = 4 * NUM_DIGITS;
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS ||
      REFRESH_DIV < GUARD_CYCLES + MIN_SLOT_MARGIN ||
      BLINK_FRAMES < MIN_BLINK_FRAMES) begin : g_bad_params
    $error("sseg_scan_ctrl: illegal parameter combination");
  end

  logic [PRE_W-1:0]      pre;
  logic [IDX_W-1:0]      idx;
  logic [FRM_W-1:0]      frm_cnt;
  logic                  blink_phase;
  logic                  pending;

  logic [HEX_W-1:0]      stg_hex,   act_hex;
  logic [NUM_DIGITS-1:0] stg_dp,    act_dp;
  logic [NUM_DIGITS-1:0] stg_en,    act_en;
  logic [NUM_DIGITS-1:0] stg_blink, act_blink;

  logic                  slot_end_c;
  logic                  wrap_c;
  logic [3:0]            sel_nib_c;
  logic                  sel_dp_c;
  logic                  sel_en_c;
  logic                  sel_blink_c;
  logic                  sel_lz_c;
  logic                  visible_c;
  logic [NUM_DIGITS-1:0] anode_c;
  seg_t                  seg_code_c;

  assign slot_end_c = (pre == PRE_W'(REFRESH_DIV - 1));
  assign wrap_c     = slot_end_c && (idx == IDX_W'(NUM_DIGITS - 1));

  // Prescaler and digit index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
      idx <= '0;
    end else if (slot_end_c) begin
      pre <= '0;
      idx <= wrap_c ? '0 : idx + IDX_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Frame counter, blink phase and frame pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= wrap_c;
      if (wrap_c) begin
        if (frm_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frm_cnt     <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frm_cnt <= frm_cnt + FRM_W'(1);
        end
      end
    end
  end

  // Staging captures every load; active set only changes on the wrap cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= 1'b0;
      stg_hex   <= '0;
      stg_dp    <= '0;
      stg_en    <= '0;
      stg_blink <= '0;
      act_hex   <= '0;
      act_dp    <= '0;
      act_en    <= '0;
      act_blink <= '0;
    end else begin
      if (load) begin
        stg_hex   <= hex_data;
        stg_dp    <= dp_in;
        stg_en    <= digit_en;
        stg_blink <= blink_en;
        pending   <= 1'b1;
      end
      if (wrap_c) begin
        pending <= 1'b0;
        if (load) begin
          act_hex   <= hex_data;
          act_dp    <= dp_in;
          act_en    <= digit_en;
          act_blink <= blink_en;
        end else if (pending) begin
          act_hex   <= stg_hex;
          act_dp    <= stg_dp;
          act_en    <= stg_en;
          act_blink <= stg_blink;
        end
      end
    end
  end

  // Select the current digit; lz_run tracks "this and all higher digits are zero"
  always_comb begin
    logic lz_run;
    sel_nib_c   = '0;
    sel_dp_c    = 1'b0;
    sel_en_c    = 1'b0;
    sel_blink_c = 1'b0;
    sel_lz_c    = 1'b0;
    lz_run      = lz_blank;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      lz_run = lz_run && (act_hex[4*k +: 4] == 4'h0);
      if (idx == IDX_W'(k)) begin
        sel_nib_c   = act_hex[4*k +: 4];
        sel_dp_c    = act_dp[k];
        sel_en_c    = act_en[k];
        sel_blink_c = act_blink[k];
        sel_lz_c    = lz_run && (k != 0);
      end
    end
  end

  assign visible_c = sel_en_c && !sel_lz_c && !(blink_phase && sel_blink_c) &&
                     (pre >= PRE_W'(GUARD_CYCLES));

  always_comb begin
    anode_c = '1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      anode_c[k] = !(visible_c && (idx == IDX_W'(k)));
    end
  end

  sseg_decode u_decode (
    .nibble (sel_nib_c),
    .dp     (sel_dp_c),
    .seg_c  (seg_code_c)
  );

  // Registered pin drivers; async reset darkens the display immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode   <= '1;
      cathode <= SEG_BLANK;
    end else begin
      anode   <= anode_c;
      cathode <= visible_c ? seg_code_c : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized self-checking bench for sseg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
module tb_sseg_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int          SLOT  = 8;
  localparam int          FRAME = 32;
  localparam int          GUARD = 2;
  localparam int          BLINK = 2;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [15:0] hex_data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic        lz_blank;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  sseg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (SLOT),
    .GUARD_CYCLES (GUARD),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .hex_data   (hex_data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blink_en   (blink_en),
    .lz_blank   (lz_blank),
    .anode      (anode),
    .cathode    (cathode),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  logic [7:0] segtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: cyc counts clock edges since reset release; the displayed
  // content changes only at frame boundaries (every FRAME cycles), last load wins.
  int          cyc;
  logic [15:0] m_hex, st_hex, p_hex;
  logic [3:0]  m_dp, st_dp, p_dp;
  logic [3:0]  m_en, st_en, p_en;
  logic [3:0]  m_bl, st_bl, p_bl;
  logic        pend, lz_e;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc <= 0;
      m_hex <= '0; m_dp <= '0; m_en <= '0; m_bl <= '0;
      st_hex <= '0; st_dp <= '0; st_en <= '0; st_bl <= '0;
      p_hex <= '0; p_dp <= '0; p_en <= '0; p_bl <= '0;
      pend <= 1'b0;
      lz_e <= 1'b0;
    end else begin
      cyc   <= cyc + 1;
      p_hex <= m_hex; p_dp <= m_dp; p_en <= m_en; p_bl <= m_bl;
      lz_e  <= lz_blank;
      if (load) begin
        st_hex <= hex_data; st_dp <= dp_in; st_en <= digit_en; st_bl <= blink_en;
      end
      if (cyc % FRAME == FRAME - 1) begin
        pend <= 1'b0;
        if (load) begin
          m_hex <= hex_data; m_dp <= dp_in; m_en <= digit_en; m_bl <= blink_en;
        end else if (pend) begin
          m_hex <= st_hex; m_dp <= st_dp; m_en <= st_en; m_bl <= st_bl;
        end
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

  // Expected pins for the cycle just completed (outputs lag the scan by one cycle)
  function automatic void exp_out(output logic [3:0] ea, output logic [7:0] ec);
    int s, k, pre;
    logic ph;
    logic [3:0] nib;
    ea = 4'hF;
    ec = 8'hFF;
    if (cyc == 0) return;
    s   = cyc - 1;
    pre = s % SLOT;
    k   = (s / SLOT) % int'(ND);
    ph  = (((s / FRAME) / BLINK) % 2) == 1;
    nib = p_hex[4*k +: 4];
    if (p_en[k] && pre >= GUARD && !(ph && p_bl[k]) &&
        !(lz_e && k > 0 && (p_hex >> (4*k)) == 16'h0)) begin
      ea = ~(4'b0001 << k);
      ec = {~p_dp[k], segtab[nib][6:0]};
    end
  endfunction

  task automatic do_load(input logic [15:0] h, input logic [3:0] dp,
                         input logic [3:0] en, input logic [3:0] bl);
    hex_data = h; dp_in = dp; digit_en = en; blink_en = bl; load = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    hex_data = 16'($urandom);
    dp_in    = 4'($urandom);
    digit_en = 4'($urandom);
    blink_en = 4'($urandom);
  endtask

  task automatic sync_to(input int ph);
    for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != ph; i++) @(negedge clk);
    n_cmp++;
    if ((cyc % FRAME) != ph) begin
      n_bad++;
      $display("FAIL sync_to: frame position %0d, required %0d", cyc % FRAME, ph);
    end
  endtask

  task automatic test_reset();
    logic [3:0] ea; logic [7:0] ec; logic eft;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (anode !== 4'hF || cathode !== 8'hFF || frame_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: anode=%h cathode=%h tick=%b, required F/FF/0", anode, cathode, frame_tick);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      exp_out(ea, ec);
      eft = (cyc != 0) && (cyc % FRAME == 0);
      n_cmp++;
      if (anode !== ea || cathode !== ec || frame_tick !== eft) begin
        n_bad++;
        $display("FAIL reset_dark cyc=%0d: got %h/%h/%b, required %h/%h/%b",
                 cyc, anode, cathode, frame_tick, ea, ec, eft);
      end
    end
    do_load(16'h1234, 4'h0, 4'hF, 4'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      exp_out(ea, ec);
      if (ea != 4'hF) break;
    end
    n_cmp++;
    if (anode === 4'hF) begin
      n_bad++;
      $display("FAIL reset_prelit: anode=%h, required a lit digit before reset", anode);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (anode !== 4'hF || cathode !== 8'hFF) begin
      n_bad++;
      $display("FAIL reset_async: anode=%h cathode=%h, required F/FF", anode, cathode);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      exp_out(ea, ec);
      eft = (cyc != 0) && (cyc % FRAME == 0);
      n_cmp++;
      if (anode !== ea || cathode !== ec || frame_tick !== eft) begin
        n_bad++;
        $display("FAIL reset_restart cyc=%0d: got %h/%h/%b, required %h/%h/%b",
                 cyc, anode, cathode, frame_tick, ea, ec, eft);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] ea; logic [7:0] ec;
    lz_blank = 1'b0;
    sync_to(10);
    do_load(16'h1234, 4'h0, 4'hF, 4'h0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      exp_out(ea, ec);
      n_cmp++;
      if (anode !== ea || cathode !== ec) begin
        n_bad++;
        $display("FAIL basic cyc=%0d: got %h/%h, required %h/%h", cyc, anode, cathode, ea, ec);
      end
    end
  endtask

  task automatic test_decode();
    logic [3:0] ea; logic [7:0] ec;
    for (int v = 0; v < 16; v++) begin
      do_load(16'(v), {3'b000, 1'($urandom)}, 4'b0001, 4'h0);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        exp_out(ea, ec);
        n_cmp++;
        if (anode !== ea || cathode !== ec) begin
          n_bad++;
          $display("FAIL decode v=%h cyc=%0d: got %h/%h, required %h/%h", v, cyc, anode, cathode, ea, ec);
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [3:0] ea; logic [7:0] ec;
    logic [15:0] pats [2] = '{16'h0070, 16'h0000};
    lz_blank = 1'b1;
    for (int p = 0; p < 3; p++) begin
      if (p < 2) do_load(pats[p], 4'h0, 4'hF, 4'h0);
      else lz_blank = 1'b0;
      for (int i = 0; i < 72; i++) begin
        @(negedge clk);
        exp_out(ea, ec);
        n_cmp++;
        if (anode !== ea || cathode !== ec) begin
          n_bad++;
          $display("FAIL lz_blank p=%0d cyc=%0d: got %h/%h, required %h/%h", p, cyc, anode, cathode, ea, ec);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] ea; logic [7:0] ec;
    do_load(16'h8421 | 16'($urandom), 4'($urandom), 4'hF, 4'b0001);
    for (int i = 0; i < 6 * FRAME; i++) begin
      @(negedge clk);
      exp_out(ea, ec);
      n_cmp++;
      if (anode !== ea || cathode !== ec) begin
        n_bad++;
        $display("FAIL blink cyc=%0d: got %h/%h, required %h/%h", cyc, anode, cathode, ea, ec);
      end
    end
  endtask

  task automatic test_tear_free();
    logic [3:0] ea; logic [7:0] ec;
    sync_to(3);
    do_load(16'h1234, 4'h0, 4'hF, 4'h0);
    repeat (4) @(negedge clk);
    do_load(16'hABCD, 4'h0, 4'hF, 4'h0);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      exp_out(ea, ec);
      n_cmp++;
      if (anode !== ea || cathode !== ec) begin
        n_bad++;
        $display("FAIL tear_last_wins cyc=%0d: got %h/%h, required %h/%h", cyc, anode, cathode, ea, ec);
      end
    end
    sync_to(FRAME - 1);
    do_load(16'h5678, 4'h0, 4'hF, 4'h0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_out(ea, ec);
      n_cmp++;
      if (anode !== ea || cathode !== ec) begin
        n_bad++;
        $display("FAIL tear_wrap_load cyc=%0d: got %h/%h, required %h/%h", cyc, anode, cathode, ea, ec);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ea; logic [7:0] ec;
    for (int it = 0; it < 20; it++) begin
      int gap;
      gap = int'($urandom_range(0, 45));
      if ($urandom_range(0, 3) == 0) lz_blank = ~lz_blank;
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        exp_out(ea, ec);
        n_cmp++;
        if (anode !== ea || cathode !== ec) begin
          n_bad++;
          $display("FAIL random it=%0d cyc=%0d: got %h/%h, required %h/%h", it, cyc, anode, cathode, ea, ec);
        end
      end
      do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; load = 1'b0; hex_data = '0;
    dp_in = '0; digit_en = '0; blink_en = '0; lz_blank = 1'b0;
    test_reset();
    test_basic();
    test_decode();
    test_lz_blank();
    test_blink();
    test_tear_free();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sseg_scan_ctrl.md
# sseg_scan_ctrl

Parametrised multi-digit seven-segment display controller. Time-multiplexes up to 16 hex digits onto one shared active-low cathode bus with active-low anodes. Adds per-digit decimal point, enable, blink and leading-zero blanking, with frame-synchronous shadow loading so the display never shows a torn value. Sits between the datapath registers and the board's display pins, replacing per-digit combinational decoding.

## Interface
- NUM_DIGITS, 8: digits scanned; legal 1..16
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ GUARD_CYCLES+2
- GUARD_CYCLES, 4: anti-ghosting dead time at the start of each slot, all anodes off
- BLINK_FRAMES, 256: frames per blink half-period; ≥1
---
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe; captures the four data inputs below
- hex_data  in  4*NUM_DIGITS  digit k = hex_data[4k+3:4k]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- digit_en  in  NUM_DIGITS  1 = digit displayed
- blink_en  in  NUM_DIGITS  1 = digit blinks
- lz_blank  in  1  live level, not shadowed; 1 = blank leading zeros
- anode  out  NUM_DIGITS  active-low digit select, registered
- cathode  out  8  active-low {dp,g,f,e,d,c,b,a}, registered
- frame_tick  out  1  one-cycle pulse per completed frame

## Operation
- Prescaler `pre` counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and `idx` advances. `idx` wraps from NUM_DIGITS-1 to 0; that cycle is the "wrap cycle".
- Shadow loading:
  - `load` copies the inputs into staging and sets `pending`.
  - On the wrap cycle:
    - if `load`=1, the inputs go directly to the active set;
    - else if `pending`=1, staging goes to the active set;
    - `pending` clears in both cases.
  - The scan always uses the active set only.
  - Multiple loads within one frame: the last load wins.
- Decode, full 16 codes, dp bit = ~dp: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. Values are listed with dp off.
- Digit k is visible when all of the following hold:
  - digit_en[k]=1;
  - it is not leading-zero blanked;
  - it is not blinked off;
  - `pre` ≥ GUARD_CYCLES.
- Leading-zero blanking (lz_blank=1): digit k>0 is blanked when it and every higher digit are 0. Digit 0 is never zero-blanked. dp does not inhibit blanking.
- Blink: a frame counter toggles `blink_phase` every BLINK_FRAMES frames. When `blink_phase`=1, digits with blink_en set are off.
- Visible slot: anode = ~(1<<idx), cathode = decoded code.
- Invisible slot: anode all 1, cathode 8'hFF.
- Reset values:
  - anode all 1, cathode 8'hFF, frame_tick 0;
  - `pre`, `idx`, `pending`, `blink_phase` and the frame counter all 0;
  - active and staging registers 0, so digit_en=0 and the display is dark until the first load is applied.

## Timing
- Outputs are registered: anode and cathode reflect the `pre`/`idx` state of the previous cycle.
- Slot length is REFRESH_DIV cycles; frame length is NUM_DIGITS*REFRESH_DIV cycles.
- frame_tick is high in the cycle after the wrap cycle.
- Load-to-display latency ranges from 1 cycle + remaining frame (worst case one full frame) to 1 cycle when load coincides with the wrap cycle.
- lz_blank changes take effect one cycle later.
- Reset assertion mid-slot forces anode/cathode to blank immediately, without waiting for clk. After release, the scan restarts at digit 0 with `pre`=0.
- NUM_DIGITS=1: every slot end is a wrap cycle.

## Structure
- Shared package sseg_pkg holds:
  - the 16 segment-code constants and SEG_BLANK = 8'hFF;
  - the segment bit-order definition;
  - the parameter legality limits.
- Sub-module sseg_decode: combinational nibble + dp → 8-bit active-low code, instantiated once on the selected digit.
- Top level holds prescaler, index, shadow registers, blink counter, blanking logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_FRAMES=2.
- Reset: assert reset_n mid-slot → anode=4'hF, cathode=8'hFF asynchronously. After release, no digit lights before the first load; frame_tick period is 32 cycles.
- Load hex_data=16'h1234, digit_en=4'hF → after the next wrap, slot 0 gives anode 4'hE / cathode 99, slot 1 4'hD/B0, slot 2 4'hB/A4, slot 3 4'h7/F9. Anodes are 4'hF for the first 2 cycles of each slot.
- Decode sweep: digit 0 loaded with 0..F, dp_in toggled → each code matches the list, including 9→90 and F→8E; dp=1 clears bit 7.
- Leading-zero blanking, lz_blank=1:
  - 16'h0070 → digits 3 and 2 dark, digit 1 F8, digit 0 C0;
  - 16'h0000 → only digit 0 lit, showing C0;
  - lz_blank=0 → all four lit.
- Blink: blink_en=4'b0001 → digit 0 dark in alternate 2-frame periods, other digits unaffected.
- Tear-free loading:
  - load 16'h1234, then 16'hABCD before the wrap → no frame ever shows 1234 or a mix of the two values;
  - load asserted on the wrap cycle → new value visible in the immediately following frame.
